// File: rtl/multi_ch_gain.sv
// multi_ch_gain: time-multiplexed, per-channel programmable gain stage.
// Pipeline: S1 captures sample, tag and channel gain; S2 forms the exact
// signed product; S3 rounds, shifts and saturates into the output register.
// The whole pipeline advances together whenever the output can move.
// Optional saturation event counter: define MULTI_CH_GAIN_SAT_CNT_EN.
module multi_ch_gain #(
  parameter int          DW       = 16,
  parameter int          GW       = 16,
  parameter int          OW       = 16,
  parameter int          NCH      = 4,
  parameter int          SHW      = 5,
  parameter int unsigned GAIN_RST = 1,
  localparam int         CW       = $clog2(NCH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  input  logic [CW-1:0] ch_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [OW-1:0] data_o,
  output logic [CW-1:0] ch_o,
  output logic          sat_o,
  input  logic [SHW-1:0] shift_i,
  input  logic          cfg_we_i,
  input  logic [CW-1:0] cfg_addr_i,
  input  logic [GW-1:0] cfg_gain_i,
  output logic [15:0]   sat_cnt_o
);

  // Product width holds any signed-by-unsigned result exactly; one extra
  // bit in the rounding path keeps the rounding bias from overflowing.
  localparam int PW = DW + GW + 1;
  localparam int RW = PW + 1;
  localparam logic [CW:0] NCH_W = (CW+1)'(NCH);
  localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [GW-1:0] gain_q [NCH];
  logic [GW-1:0] gain_sel_s;
  logic          ch_ok_s;
  logic          addr_ok_s;
  logic          adv_s;

  logic          s1_valid_q;
  logic [DW-1:0] s1_data_q;
  logic [CW-1:0] s1_ch_q;
  logic [GW-1:0] s1_gain_q;

  logic signed [PW-1:0] mul_a_s;
  logic signed [PW-1:0] mul_b_s;
  logic signed [PW-1:0] prod_s;

  logic                 s2_valid_q;
  logic signed [PW-1:0] s2_prod_q;
  logic [CW-1:0]        s2_ch_q;

  logic [31:0]          sh_s;
  logic signed [RW-1:0] p_ext_s;
  logic signed [RW-1:0] bias_s;
  logic signed [RW-1:0] sum_s;
  logic signed [RW-1:0] r_s;
  logic [OW-1:0]        data_d;
  logic                 sat_d;

  logic          out_valid_q;
  logic [OW-1:0] out_data_q;
  logic [CW-1:0] out_ch_q;
  logic          out_sat_q;

  assign ch_ok_s   = ({1'b0, ch_i} < NCH_W);
  assign addr_ok_s = ({1'b0, cfg_addr_i} < NCH_W);

  // The pipeline moves as a unit whenever the output register is free or draining.
  assign adv_s   = ready_i || !out_valid_q;
  assign ready_o = adv_s;

  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;
  assign ch_o    = out_ch_q;
  assign sat_o   = out_sat_q;

  // Gain register file; writes are independent of pipeline stalls.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NCH; i++) begin
        gain_q[i] <= GW'(GAIN_RST);
      end
    end else if (cfg_we_i && addr_ok_s) begin
      gain_q[cfg_addr_i] <= cfg_gain_i;
    end
  end

  // Gain lookup for the incoming sample; unknown channels get zero gain.
  always_comb begin
    gain_sel_s = {GW{1'b0}};
    if (ch_ok_s) begin
      gain_sel_s = gain_q[ch_i];
    end else begin
      gain_sel_s = {GW{1'b0}};
    end
  end

  // Exact signed product of the sample and the zero-extended gain.
  always_comb begin
    mul_a_s = {{(PW-DW){s1_data_q[DW-1]}}, s1_data_q};
    mul_b_s = {{(PW-GW){1'b0}}, s1_gain_q};
    prod_s  = mul_a_s * mul_b_s;
  end

  // Round-half-up right shift followed by clipping to the output range.
  always_comb begin
    sh_s    = 32'(shift_i);
    p_ext_s = {s2_prod_q[PW-1], s2_prod_q};
    bias_s  = {RW{1'b0}};
    sum_s   = p_ext_s;
    r_s     = p_ext_s;
    data_d  = {OW{1'b0}};
    sat_d   = 1'b0;
    if (sh_s == 32'd0) begin
      r_s = p_ext_s;
    end else if (sh_s > 32'(PW)) begin
      // Bias 2^(s-1) exceeds any product magnitude, so the rounded value is 0.
      r_s = {RW{1'b0}};
    end else begin
      bias_s = {{(RW-1){1'b0}}, 1'b1} << (sh_s - 32'd1);
      sum_s  = p_ext_s + bias_s;
      r_s    = sum_s >>> sh_s;
    end
    if (r_s > OUT_MAX) begin
      data_d = OUT_MAX[OW-1:0];
      sat_d  = 1'b1;
    end else if (r_s < OUT_MIN) begin
      data_d = OUT_MIN[OW-1:0];
      sat_d  = 1'b1;
    end else begin
      data_d = r_s[OW-1:0];
      sat_d  = 1'b0;
    end
  end

  // Three pipeline stages; reset drops every in-flight sample.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {DW{1'b0}};
      s1_ch_q     <= {CW{1'b0}};
      s1_gain_q   <= {GW{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= {PW{1'b0}};
      s2_ch_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OW{1'b0}};
      out_ch_q    <= {CW{1'b0}};
      out_sat_q   <= 1'b0;
    end else if (adv_s) begin
      s1_valid_q  <= valid_i;
      s1_data_q   <= data_i;
      s1_ch_q     <= ch_i;
      s1_gain_q   <= gain_sel_s;
      s2_valid_q  <= s1_valid_q;
      s2_prod_q   <= prod_s;
      s2_ch_q     <= s1_ch_q;
      out_valid_q <= s2_valid_q;
      out_data_q  <= data_d;
      out_ch_q    <= s2_ch_q;
      out_sat_q   <= sat_d;
    end
  end

`ifdef MULTI_CH_GAIN_SAT_CNT_EN
  logic [15:0] sat_cnt_q;
  logic [15:0] sat_cnt_d;

  // Count clipped output transfers, sticking at all-ones; config writes clear.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (cfg_we_i) begin
      sat_cnt_d = 16'h0000;
    end else if (out_valid_q && ready_i && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'h0001;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_cnt_q <= 16'h0000;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`else
  assign sat_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_multi_ch_gain.sv
// Self-checking bench for multi_ch_gain: scoreboard fed by a behavioural
// model (plain integer arithmetic), directed literal checks and random traffic.
module tb_multi_ch_gain;
  localparam int NCH = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i, valid_i, ready_o, valid_o, ready_i, sat_o, cfg_we_i;
  logic [15:0] data_i, data_o, cfg_gain_i, sat_cnt_o;
  logic [1:0]  ch_i, ch_o, cfg_addr_i;
  logic [4:0]  shift_i;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  ch;
    logic        sat;
  } exp_t;

  exp_t        q[$];
  int unsigned mgain [NCH];
  int unsigned mcnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  multi_ch_gain dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .ch_i(ch_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .ch_o(ch_o), .sat_o(sat_o), .shift_i(shift_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_gain_i(cfg_gain_i),
    .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: P = d*g, round half up by 2^s, clip to 16-bit signed.
  function automatic void model_calc(input logic signed [15:0] d, input int unsigned g,
                                     input int s, output logic [15:0] r, output logic sat);
    longint p, rr;
    p = longint'(d) * longint'(g);
    if (s == 0) rr = p;
    else rr = (p + (longint'(1) <<< (s - 1))) >>> s;
    if (rr > 32767) begin r = 16'h7FFF; sat = 1'b1; end
    else if (rr < -32768) begin r = 16'h8000; sat = 1'b1; end
    else begin r = rr[15:0]; sat = 1'b0; end
  endfunction

  // One negedge worth of scoreboard work: check outputs, then record this cycle's
  // transfers and configuration writes.
  task automatic monitor_cycle();
    exp_t        e;
    logic [15:0] r;
    logic        s;
    if (!rstn_i) begin
      chk("valid_o in reset", {31'd0, valid_o}, 32'd0);
      q.delete();
      for (int i = 0; i < NCH; i++) mgain[i] = 1;
      mcnt = 0;
      return;
    end
    chk("ready_o rule", {31'd0, ready_o}, {31'd0, ready_i | ~valid_o});
`ifdef MULTI_CH_GAIN_SAT_CNT_EN
    chk("sat_cnt_o", {16'd0, sat_cnt_o}, mcnt);
`else
    chk("sat_cnt_o tied off", {16'd0, sat_cnt_o}, 32'd0);
`endif
    if (valid_o) begin
      if (q.size() == 0) begin
        chk("valid_o with empty model", {31'd0, valid_o}, 32'd0);
      end else begin
        e = q[0];
        chk("data_o", {16'd0, data_o}, {16'd0, e.d});
        chk("ch_o", {30'd0, ch_o}, {30'd0, e.ch});
        chk("sat_o", {31'd0, sat_o}, {31'd0, e.sat});
        if (ready_i) begin
          void'(q.pop_front());
          if (e.sat && mcnt != 32'hFFFF) mcnt++;
        end
      end
    end
    if (valid_i && ready_o) begin
      model_calc(data_i, mgain[ch_i], int'(shift_i), r, s);
      e.d = r; e.ch = ch_i; e.sat = s;
      q.push_back(e);
    end
    if (cfg_we_i) begin
      mgain[cfg_addr_i] = cfg_gain_i;
      mcnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_gain(input logic [1:0] a, input logic [15:0] g);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_gain_i = g;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    valid_i = 1'b0; ready_i = 1'b1;
    while (q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  // Send one sample into an idle pipeline and pin the result 3 cycles later.
  task automatic send_chk(input string nm, input logic [15:0] d, input logic [1:0] ch,
                          input logic [15:0] ed, input logic es);
    ready_i = 1'b1; valid_i = 1'b1; data_i = d; ch_i = ch;
    tick();
    valid_i = 1'b0;
    tick();
    chk({nm, " not early"}, {31'd0, valid_o}, 32'd0);
    tick();
    chk({nm, " valid"}, {31'd0, valid_o}, 32'd1);
    chk({nm, " data"}, {16'd0, data_o}, {16'd0, ed});
    chk({nm, " ch"}, {30'd0, ch_o}, {30'd0, ch});
    chk({nm, " sat"}, {31'd0, sat_o}, {31'd0, es});
  endtask

  task automatic run_tests();
    int idx, cyc;
    logic acc;
    int shifts [8];
    shifts = '{0, 1, 3, 8, 15, 16, 20, 31};

    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = 16'h0000; ch_i = 2'd0;
    shift_i = 5'd0; cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_gain_i = 16'h0000;
    #2;
    chk("reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset data_o", {16'd0, data_o}, 32'd0);
    chk("reset ch_o", {30'd0, ch_o}, 32'd0);
    chk("reset sat_o", {31'd0, sat_o}, 32'd0);
    chk("reset sat_cnt_o", {16'd0, sat_cnt_o}, 32'd0);
    tick(); tick();
    rstn_i = 1'b1;
    tick();

    // Unity path on every channel.
    for (int c = 0; c < 4; c++) write_gain(2'(c), 16'd1);
    for (int c = 0; c < 4; c++) begin
      send_chk("unity pos", 16'd100, 2'(c), 16'd100, 1'b0);
      send_chk("unity neg", 16'hFF9C, 2'(c), 16'hFF9C, 1'b0);
    end
    drain();

    // Per-channel gain with rounding.
    write_gain(2'd2, 16'd3);
    shift_i = 5'd1;
    send_chk("round pos", 16'd5, 2'd2, 16'd8, 1'b0);
    send_chk("round neg", 16'hFFFB, 2'd2, 16'hFFF9, 1'b0);
    drain();

    // Saturation at both rails.
    shift_i = 5'd0;
    write_gain(2'd1, 16'hFFFF);
    send_chk("sat hi", 16'h7FFF, 2'd1, 16'h7FFF, 1'b1);
    send_chk("sat lo", 16'h8000, 2'd1, 16'h8000, 1'b1);
    tick();
`ifdef MULTI_CH_GAIN_SAT_CNT_EN
    chk("sat_cnt after two clips", {16'd0, sat_cnt_o}, 32'd2);
`endif
    drain();

    // Gain update racing a same-channel accept.
    write_gain(2'd0, 16'd1);
    ready_i = 1'b1; valid_i = 1'b1; data_i = 16'd7; ch_i = 2'd0;
    cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_gain_i = 16'd4;
    tick();
    valid_i = 1'b0; cfg_we_i = 1'b0;
    tick(); tick();
    chk("race old gain valid", {31'd0, valid_o}, 32'd1);
    chk("race old gain data", {16'd0, data_o}, 32'd7);
    send_chk("race new gain", 16'd7, 2'd0, 16'd28, 1'b0);
    drain();

    // Backpressure: 10 samples with a 5-cycle ready_i drop mid-stream.
    for (int c = 0; c < 4; c++) write_gain(2'(c), 16'd1);
    idx = 0; cyc = 0;
    while (idx < 10 && cyc < 60) begin
      ready_i = !(cyc >= 5 && cyc < 10);
      valid_i = 1'b1; data_i = 16'(idx * 11 + 1); ch_i = 2'(idx);
      #1;
      if (!ready_i && valid_o) chk("ready_o under stall", {31'd0, ready_o}, 32'd0);
      acc = ready_o;
      tick();
      if (acc) idx++;
      cyc++;
    end
    valid_i = 1'b0;
    chk("stream accepted", idx, 32'd10);
    drain();

    // Reset with three samples in flight.
    write_gain(2'd2, 16'd3);
    write_gain(2'd1, 16'hFFFF);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; data_i = 16'(50 + i); ch_i = 2'(i);
      tick();
    end
    valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk("async reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("async reset data_o", {16'd0, data_o}, 32'd0);
    tick(); tick();
    rstn_i = 1'b1;
    repeat (6) tick();
    chk("no stale output", {31'd0, valid_o}, 32'd0);
    send_chk("gain reset ch2", 16'd9, 2'd2, 16'd9, 1'b0);
    send_chk("gain reset ch1", 16'd9, 2'd1, 16'd9, 1'b0);
    drain();

    // Random traffic per shift setting; shift changes only with an empty pipeline.
    for (int p = 0; p < 8; p++) begin
      shift_i = 5'(shifts[p]);
      for (int n = 0; n < 120; n++) begin
        valid_i = ($urandom_range(0, 9) < 7);
        ch_i = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) data_i = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
        else data_i = 16'($urandom);
        ready_i = ($urandom_range(0, 3) != 0);
        cfg_we_i = ($urandom_range(0, 15) == 0);
        cfg_addr_i = 2'($urandom_range(0, 3));
        cfg_gain_i = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
        tick();
      end
      cfg_we_i = 1'b0;
      drain();
    end
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk_i);
          monitor_cycle();
        end
      end
      begin
        run_tests();
      end
      begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
